async_event_arbiter: RTL

- Collects rising-edge events from N_CH asynchronous inputs and delivers them one at a time, tagged with a channel ID, over a valid/ready interface.
- Each channel has its own internal synchronizer chain, edge detector and pending flag.
- A round-robin scheduler shares the single event output among channels.
- Sits between external async sources (buttons, IRQ lines, peripheral flags) and the synchronous control logic.

---
 rtl/async_event_arbiter.sv | 100 ++++++++++
 1 files changed

// File: rtl/async_event_arbiter.sv
// Collects rising edges from N_CH asynchronous lines and hands them out one at a
// time, tagged with a channel ID, over a valid/ready interface (round-robin).
module async_event_arbiter #(
  parameter  int N_CH        = 4,
  parameter  int SYNC_STAGES = 2,
  localparam int ID_W        = $clog2(N_CH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [N_CH-1:0]   async_i,
  output logic              event_valid_o,
  input  logic              event_ready_i,
  output logic [ID_W-1:0]   event_id_o,
  output logic [N_CH-1:0]   pending_o,
  output logic [N_CH-1:0]   overflow_o,
  input  logic              clr_overflow_i
);

  logic [N_CH-1:0] w_pending;
  logic [N_CH-1:0] w_grant_vec;
  logic            w_free;
  logic            w_grant;
  logic            w_found;
  logic [ID_W-1:0] w_gid;

  logic            r_valid;
  logic [ID_W-1:0] r_id;
  logic [ID_W-1:0] r_ptr;

  // Per-channel synchronizer, edge detector, pending and sticky overflow state.
  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      logic [SYNC_STAGES-1:0] r_chain;
      logic                   r_prev;
      logic                   r_pend;
      logic                   r_ovf;
      logic                   w_sync;
      logic                   w_rise;

      assign w_sync          = r_chain[SYNC_STAGES-1];
      assign w_rise          = w_sync & ~r_prev;
      assign w_grant_vec[gi] = w_grant & (w_gid == ID_W'(gi));
      assign w_pending[gi]   = r_pend;
      assign overflow_o[gi]  = r_ovf;

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          r_chain <= '0;
          r_prev  <= 1'b0;
          r_pend  <= 1'b0;
          r_ovf   <= 1'b0;
        end else begin
          r_chain <= {r_chain[SYNC_STAGES-2:0], async_i[gi]};
          r_prev  <= w_sync;
          // A rise coinciding with a grant re-queues; a rise onto an ungranted pending is lost.
          r_pend  <= w_rise | (r_pend & ~w_grant_vec[gi]);
          r_ovf   <= (r_ovf & ~clr_overflow_i) | (w_rise & r_pend & ~w_grant_vec[gi]);
        end
      end
    end
  endgenerate

  assign w_free  = ~r_valid | event_ready_i;
  assign w_grant = w_free & w_found;

  // First pending channel after the pointer, wrapping modulo N_CH.
  always_comb begin
    w_found = 1'b0;
    w_gid   = '0;
    for (int i = 0; i < N_CH; i++) begin
      for (int k = 0; k < N_CH; k++) begin
        if (!w_found && w_pending[k] && (k == ((int'(r_ptr) + 1 + i) % N_CH))) begin
          w_found = 1'b1;
          w_gid   = ID_W'(k);
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_valid <= 1'b0;
      r_id    <= '0;
      r_ptr   <= ID_W'(N_CH - 1);
    end else if (w_free) begin
      if (w_found) begin
        r_valid <= 1'b1;
        r_id    <= w_gid;
        r_ptr   <= w_gid;
      end else begin
        r_valid <= 1'b0;
      end
    end
  end

  assign event_valid_o = r_valid;
  assign event_id_o    = r_id;
  assign pending_o     = w_pending;

endmodule
